quantum_scheduler: RTL and testbench

QUANTUM_SCHEDULER -- requirements
Module: quantum_scheduler

---
 rtl/sched_pkg.sv | 20 ++
 rtl/rr_pick.sv | 35 +++
 rtl/quantum_scheduler.sv | 144 ++++++++++++++
 tb/tb_quantum_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sched_pkg
// Brief    : Shared constants for the quantum scheduler: slot count, slot-id
//            width and controller state encoding.
// Revision : 1.0
// ============================================================================
package sched_pkg;

    localparam int c_NPROC = 4;
    localparam int c_ID_W  = 2;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RUN     = 3'd1;
    localparam logic [2:0] c_ST_SAVE    = 3'd2;
    localparam logic [2:0] c_ST_SELECT  = 3'd3;
    localparam logic [2:0] c_ST_RESTORE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Round-robin slot picker; returns the first set mask bit found
//            from i_start upward, wrapping modulo the slot count.
// Revision : 1.0
// ============================================================================
module rr_pick
    import sched_pkg::*;
(
    input  logic [c_NPROC-1:0] i_mask,
    input  logic [c_ID_W-1:0]  i_start,
    output logic [c_ID_W-1:0]  o_id,
    output logic               o_valid
);

    logic [c_NPROC-1:0] w_rot;
    logic [c_ID_W-1:0]  w_off;

    // Rotating the doubled mask puts the search origin at bit 0.
    assign w_rot = 4'({i_mask, i_mask} >> i_start);

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign o_id    = i_start + w_off;
    assign o_valid = |i_mask;

endmodule
`default_nettype wire

// File: rtl/quantum_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : quantum_scheduler
// Brief    : Time-slice process scheduler with per-slot saved PCs and
//            round-robin selection. final is reserved, hence final_pulse.
// Revision : 1.0
// ============================================================================
module quantum_scheduler
    import sched_pkg::*;
#(
    parameter int QUANTUM = 16,
    parameter int NPROC   = c_NPROC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              usaQuantum,
    input  logic              step,
    input  logic              final_pulse,
    input  logic              create,
    input  logic [c_ID_W-1:0] create_id,
    input  logic [31:0]       create_pc,
    input  logic [31:0]       cur_pc,
    input  logic              switch_ack,
    output logic              switch_req,
    output logic [31:0]       restore_pc,
    output logic [c_ID_W-1:0] cur_id,
    output logic              idle,
    output logic              create_err,
    output logic [7:0]        qtm_left
);

    localparam logic [7:0] c_QTM = 8'(QUANTUM);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [NPROC-1:0]  r_active;
    logic [31:0]       r_pc_tab [NPROC];
    logic [c_ID_W-1:0] r_cur_id;
    logic [7:0]        r_count;
    logic              r_create_err;

    logic              w_save;
    logic              w_reload;
    logic              w_dec;
    logic              w_retire;
    logic              w_pick;
    logic [c_ID_W-1:0] w_pick_id;
    logic              w_pick_valid;
    logic              w_create_ok;
    logic              w_create_bad;

    rr_pick u_rr_pick (
        .i_mask  (r_active),
        .i_start (r_cur_id + 2'd1),
        .o_id    (w_pick_id),
        .o_valid (w_pick_valid)
    );

    // Loading the running slot would clobber the PC about to be saved.
    assign w_create_ok  = create && ((create_id != r_cur_id) || (r_state == c_ST_IDLE));
    assign w_create_bad = create && !w_create_ok;

    always_ff @(posedge clock) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_save      = 1'b0;
        w_reload    = 1'b0;
        w_dec       = 1'b0;
        w_retire    = 1'b0;
        w_pick      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (|r_active) w_state_nxt = c_ST_SELECT;
            end
            c_ST_RUN: begin
                // A halt wins over expiry: the dying process has no PC worth saving.
                if (final_pulse) begin
                    w_retire    = 1'b1;
                    w_state_nxt = c_ST_SELECT;
                end else if (usaQuantum && step) begin
                    if (r_count == 8'd1) begin
                        w_reload    = 1'b1;
                        w_state_nxt = c_ST_SAVE;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            c_ST_SAVE: begin
                w_save      = 1'b1;
                w_state_nxt = c_ST_SELECT;
            end
            c_ST_SELECT: begin
                if (w_pick_valid) begin
                    w_pick      = 1'b1;
                    w_state_nxt = c_ST_RESTORE;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RESTORE: begin
                if (switch_ack) begin
                    w_reload    = 1'b1;
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_active     <= '0;
            r_cur_id     <= '0;
            r_count      <= c_QTM;
            r_create_err <= 1'b0;
            for (int i = 0; i < NPROC; i++) r_pc_tab[i] <= '0;
        end else begin
            r_create_err <= w_create_bad;
            if (w_reload)   r_count <= c_QTM;
            else if (w_dec) r_count <= r_count - 8'd1;
            if (w_pick)     r_cur_id <= w_pick_id;
            if (w_save)     r_pc_tab[r_cur_id] <= cur_pc;
            if (w_retire)   r_active[r_cur_id] <= 1'b0;
            if (w_create_ok) begin
                r_active[create_id] <= 1'b1;
                r_pc_tab[create_id] <= create_pc;
            end
        end
    end

    assign switch_req = (r_state == c_ST_RESTORE);
    assign restore_pc = r_pc_tab[r_cur_id];
    assign cur_id     = r_cur_id;
    assign idle       = (r_state == c_ST_IDLE);
    assign create_err = r_create_err;
    assign qtm_left   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_quantum_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_quantum_scheduler
// Brief    : Directed bench for quantum_scheduler with a per-cycle reference
//            model of the scheduling rules.
// Revision : 1.0
// ============================================================================
module tb_quantum_scheduler;

    localparam int Q = 4;
    localparam int P_IDLE = 0, P_RUN = 1, P_MOVE = 2, P_ACK = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        usaQuantum = 1'b0;
    logic        step = 1'b0;
    logic        final_pulse = 1'b0;
    logic        create = 1'b0;
    logic [1:0]  create_id = 2'd0;
    logic [31:0] create_pc = 32'd0;
    logic [31:0] cur_pc = 32'd0;
    logic        switch_ack = 1'b0;
    logic        switch_req;
    logic [31:0] restore_pc;
    logic [1:0]  cur_id;
    logic        idle;
    logic        create_err;
    logic [7:0]  qtm_left;

    int tests = 0;
    int fails = 0;

    quantum_scheduler #(.QUANTUM(Q)) dut (
        .clock       (clock),
        .reset       (reset),
        .usaQuantum  (usaQuantum),
        .step        (step),
        .final_pulse (final_pulse),
        .create      (create),
        .create_id   (create_id),
        .create_pc   (create_pc),
        .cur_pc      (cur_pc),
        .switch_ack  (switch_ack),
        .switch_req  (switch_req),
        .restore_pc  (restore_pc),
        .cur_id      (cur_id),
        .idle        (idle),
        .create_err  (create_err),
        .qtm_left    (qtm_left)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus a countdown of scheduling cycles left
    // before the next process is chosen.
    int          m_phase = P_IDLE;
    int          m_wait  = 0;
    bit          m_act [4];
    logic [31:0] m_pc  [4];
    int          m_id   = 0;
    int          m_left = Q;
    bit          m_err  = 1'b0;
    bit          snap  [4];
    bit          hit;
    bit          any;
    int          nid;

    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                m_act[k] = 1'b0;
                m_pc[k]  = 32'd0;
            end
            m_phase = P_IDLE; m_wait = 0; m_id = 0; m_left = Q; m_err = 1'b0;
        end else begin
            snap  = m_act;
            m_err = create && (int'(create_id) == m_id) && (m_phase != P_IDLE);
            case (m_phase)
                P_IDLE: begin
                    any = 1'b0;
                    for (int k = 0; k < 4; k++) any = any | snap[k];
                    if (any) begin m_phase = P_MOVE; m_wait = 1; end
                end
                P_RUN: begin
                    if (final_pulse) begin
                        m_act[m_id] = 1'b0;
                        m_phase = P_MOVE; m_wait = 1;
                    end else if (usaQuantum && step) begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_left = Q; m_phase = P_MOVE; m_wait = 2;
                        end
                    end
                end
                P_MOVE: begin
                    if (m_wait == 2) begin
                        m_pc[m_id] = cur_pc;
                        m_wait = 1;
                    end else begin
                        hit = 1'b0; nid = 0;
                        for (int d = 1; d <= 4; d++)
                            if (!hit && snap[(m_id + d) % 4]) begin
                                hit = 1'b1; nid = (m_id + d) % 4;
                            end
                        if (hit) begin m_id = nid; m_phase = P_ACK; end
                        else m_phase = P_IDLE;
                    end
                end
                default: begin
                    if (switch_ack) begin m_phase = P_RUN; m_left = Q; end
                end
            endcase
            if (create && !m_err) begin
                m_act[create_id] = 1'b1;
                m_pc[create_id]  = create_pc;
            end
        end
    end

    always @(posedge clock) begin
        #2;
        chk("m_idle",       idle,       m_phase == P_IDLE);
        chk("m_switch_req", switch_req, m_phase == P_ACK);
        chk("m_cur_id",     cur_id,     m_id);
        chk("m_qtm_left",   qtm_left,   m_left);
        chk("m_create_err", create_err, m_err);
        if (m_phase == P_ACK) chk("m_restore_pc", restore_pc, m_pc[m_id]);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic ack();
        switch_ack = 1'b1; tick(); switch_ack = 1'b0;
    endtask

    task automatic steps(input int n);
        step = 1'b1; tick(n); step = 1'b0;
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick();
        chk("rst_idle", idle, 1); chk("rst_sw", switch_req, 0);
        chk("rst_qtm", qtm_left, Q); chk("rst_id", cur_id, 0);
        chk("rst_rpc", restore_pc, 0); chk("rst_err", create_err, 0);

        // First process from idle: switch request two edges after creation.
        create = 1'b1; create_id = 2'd0; create_pc = 32'h10; tick(); create = 1'b0;
        tick();
        chk("c0_sw_early", switch_req, 0);
        tick();
        chk("c0_sw", switch_req, 1); chk("c0_rpc", restore_pc, 32'h10); chk("c0_id", cur_id, 0);
        ack();
        chk("c0_run_sw", switch_req, 0); chk("c0_run_qtm", qtm_left, Q);

        // Two slots, expiry saves slot 0 and hands over to slot 1.
        create = 1'b1; create_id = 2'd1; create_pc = 32'h40;
        cur_pc = 32'h14; usaQuantum = 1'b1; step = 1'b1;
        tick(); create = 1'b0;
        tick(2);
        chk("q_left1", qtm_left, 1);
        tick(); step = 1'b0;
        chk("q_reload", qtm_left, Q); chk("q_sw_n1", switch_req, 0);
        tick();
        chk("q_sw_n2", switch_req, 0);
        tick();
        chk("q_sw_n3", switch_req, 1); chk("q_rpc", restore_pc, 32'h40); chk("q_id", cur_id, 1);
        ack();

        cur_pc = 32'h44; steps(4); tick(2);
        chk("q2_id", cur_id, 0); chk("q2_rpc_saved", restore_pc, 32'h14);
        ack();

        // Halt slot 0, then lone slot 1 expires and is reselected.
        final_pulse = 1'b1; tick(); final_pulse = 1'b0;
        tick();
        chk("f_id", cur_id, 1); chk("f_rpc", restore_pc, 32'h44);
        ack();
        cur_pc = 32'h80; steps(4); tick(2);
        chk("self_sw", switch_req, 1); chk("self_id", cur_id, 1); chk("self_rpc", restore_pc, 32'h80);
        ack();

        // Halt coincides with expiring step: no save, no reload.
        create = 1'b1; create_id = 2'd2; create_pc = 32'h200; tick(); create = 1'b0;
        steps(3);
        step = 1'b1; final_pulse = 1'b1; cur_pc = 32'h99; tick();
        step = 1'b0; final_pulse = 1'b0;
        chk("ff_qtm", qtm_left, 1); chk("ff_sw0", switch_req, 0);
        tick();
        chk("ff_sw", switch_req, 1); chk("ff_id", cur_id, 2); chk("ff_rpc", restore_pc, 32'h200);
        ack();
        final_pulse = 1'b1; tick(); final_pulse = 1'b0;
        tick();
        chk("ff_idle", idle, 1);

        // Preemption disabled, then a rejected create to the running slot.
        create = 1'b1; create_id = 2'd3; create_pc = 32'h300; tick(); create = 1'b0;
        tick(2);
        chk("c3_id", cur_id, 3); chk("c3_rpc", restore_pc, 32'h300);
        ack();
        usaQuantum = 1'b0; steps(50);
        chk("nq_qtm", qtm_left, Q); chk("nq_sw", switch_req, 0);
        create = 1'b1; create_id = 2'd3; create_pc = 32'h999; tick(); create = 1'b0;
        chk("err_pulse", create_err, 1);
        tick();
        chk("err_clear", create_err, 0);

        // Reset while a switch request is pending.
        usaQuantum = 1'b1; cur_pc = 32'h3A0; steps(4); tick(2);
        chk("pre_rst_sw", switch_req, 1); chk("pre_rst_rpc", restore_pc, 32'h3A0);
        reset = 1'b1; switch_ack = 1'b1; create = 1'b1; create_id = 2'd1; tick();
        chk("r_sw", switch_req, 0); chk("r_idle", idle, 1); chk("r_rpc", restore_pc, 0);
        reset = 1'b0; switch_ack = 1'b0; create = 1'b0;
        tick(3);
        chk("r_stay_idle", idle, 1); chk("r_id", cur_id, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
